seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Sequences what the 6-digit 7-segment display shows; drives the six i_segout1..6 inputs of rtc_adapter.
//  Arbitrates three sources: live stopwatch time, lap snapshot, status message.
//  Priority: message > lap > live.
//  Timed holds: lap for HOLD_MS with blink; message for MSG_MS. Then reverts to live.
// PARAMETERS
//  DIV_TICK  100000  i_sclk cycles per 1 ms tick (100 MHz sclk); bench uses 4
//  HOLD_MS   2000    lap snapshot display time, ticks
//  MSG_MS    1000    message display time, ticks
//  BLINK_MS  250     lap blink half-period, ticks; 0 = no blink
// PORTS
//  i_sclk        in   1   system clock, single clock domain
//  i_reset_n     in   1   asynchronous active-low reset
//  i_live_segs   in   48  live digits; [7:0]=digit1 .. [47:40]=digit6, active-low segments
//  i_lap_req     in   1   1-cycle pulse: capture i_lap_segs
//  i_lap_segs    in   48  lap snapshot data, same packing
//  i_msg_req     in   1   1-cycle pulse: capture i_msg_segs
//  i_msg_segs    in   48  message data, same packing
//  o_lap_ack     out  1   1-cycle pulse: lap data captured
//  o_msg_ack     out  1   1-cycle pulse: message data captured
//  o_segout1..6  out  8   each, to rtc_adapter i_segout1..6
//  o_src         out  2   displayed source: 00 live, 01 lap, 10 msg, 11 unused
// BEHAVIOUR
//  Reset (async, i_reset_n low):
//   - state LIVE; o_segout* = 8'hFF (all blank); o_src = 00; acks = 0.
//   - tick divider, hold timer and blink phase cleared; pending-lap flag cleared.
//  Tick:
//   - tick = 1-cycle strobe every DIV_TICK i_sclk cycles.
//   - first tick comes DIV_TICK cycles after reset release.
//  FSM states LIVE, LAP, MSG:
//   - LIVE: o_segout* <= i_live_segs, registered, 1-cycle latency.
//   - LIVE + i_msg_req -> MSG: capture i_msg_segs; o_msg_ack next cycle; timer = MSG_MS.
//   - LIVE + i_lap_req only -> LAP: capture i_lap_segs; o_lap_ack next cycle; timer = HOLD_MS; blink phase = ON.
//   - LAP:
//     - outputs the snapshot, or all 8'hFF during blink OFF phase.
//     - phase toggles every BLINK_MS ticks.
//     - timer decrements on tick; at 0 -> LIVE.
//     - new i_lap_req: recapture, ack, timer reloads to HOLD_MS, phase = ON.
//     - i_msg_req pre-empts -> MSG; the remaining lap hold is discarded.
//   - MSG:
//     - outputs captured message; timer decrements on tick.
//     - new i_msg_req: recapture, ack, reload MSG_MS.
//     - i_lap_req: capture into pending buffer, ack, set pending flag.
//     - timer 0 -> LAP if pending (flag clears, timer = HOLD_MS), else LIVE.
//  Simultaneous i_lap_req and i_msg_req (any state):
//   - msg wins; lap goes to pending; both acks pulse the same cycle.
//  Captured data is sampled on the request cycle; later input changes are ignored.
//  Output update: o_segout* / o_src change 1 cycle after the state or data change that causes them.
//  Timers: width $clog2(max(HOLD_MS, MSG_MS)+1).
//   - A request on the same cycle as expiry takes precedence over expiry.
//  Reset mid-hold: immediate blank outputs; captured buffers need not be cleared.
// STRUCTURE
//  Package seg_disp_pkg:
//   - disp_state_e {LIVE, LAP, MSG}
//   - SRC_LIVE/SRC_LAP/SRC_MSG codes
//   - SEG_BLANK = 8'hFF
//   - digit unpack function: 48 -> 6x8
//  Sub-module ms_tick_gen (DIV_TICK): counter producing the 1-cycle tick; reused by later blocks.
//  Top level: FSM, hold timer, blink counter, capture/pending registers, output register.
// TESTING
//  Parameters for all tests: DIV_TICK=4, HOLD_MS=6, MSG_MS=4, BLINK_MS=2.
//  1. Reset asserted mid-LAP, then released:
//     - o_segout* = 8'hFF, o_src = 00 while reset is low.
//     - 1 cycle after release, o_segout1 = live digit1 (e.g. 8'hC0).
//  2. i_lap_req with i_lap_segs = 48'h112233445566:
//     - o_lap_ack next cycle; o_segout6 = 8'h11, o_src = 01.
//     - Blanks after 2 ticks, reshows after 2 more; LIVE after 6 ticks.
//  3. Simultaneous lap and msg requests:
//     - both acks pulse together; o_src = 10 for 4 ticks.
//     - then o_src = 01 for 6 ticks, then 00.
//  4. i_lap_req at tick 5 of a lap hold: snapshot updates; hold restarts, 6 more ticks to LIVE.
//  5. Input change after capture: i_msg_segs changes the cycle after i_msg_req; output keeps the captured value.
//  6. Live tracking in LIVE: each i_live_segs change appears on o_segout* exactly 1 cycle later.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared types, source codes and digit helpers for the segment display arbiter.
package seg_disp_pkg;

   typedef enum logic [1:0] {LIVE, LAP, MSG} disp_state_e;

   typedef logic [5:0][7:0] digits_t;

   localparam logic [1:0]  SRC_LIVE  = 2'b00;
   localparam logic [1:0]  SRC_LAP   = 2'b01;
   localparam logic [1:0]  SRC_MSG   = 2'b10;
   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam logic [47:0] ALL_BLANK = {6{SEG_BLANK}};

   function automatic digits_t unpack_digits(input logic [47:0] segs);
      digits_t d;
      for (int i = 0; i < 6; i++) d[i] = segs[8*i +: 8];
      return d;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running divider emitting a registered 1-cycle tick every DIV_TICK clocks.
module ms_tick_gen #(
   parameter int DIV_TICK = 100000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int W = DIV_TICK > 1 ? $clog2(DIV_TICK) : 1;

   logic [W-1:0] cnt_q, cnt_d;
   logic         tick_q;
   logic         wrap;

   assign wrap   = cnt_q == W'(DIV_TICK - 1);
   assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
   assign tick_o = tick_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap;
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: picks message, lap snapshot or live time for the 6-digit display,
// with timed holds and lap blinking; all outputs are registered.
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int DIV_TICK = 100000,
   parameter int HOLD_MS  = 2000,
   parameter int MSG_MS   = 1000,
   parameter int BLINK_MS = 250
) (
   input  logic        i_sclk,
   input  logic        i_reset_n,
   input  logic [47:0] i_live_segs,
   input  logic        i_lap_req,
   input  logic [47:0] i_lap_segs,
   input  logic        i_msg_req,
   input  logic [47:0] i_msg_segs,
   output logic        o_lap_ack,
   output logic        o_msg_ack,
   output logic [7:0]  o_segout1,
   output logic [7:0]  o_segout2,
   output logic [7:0]  o_segout3,
   output logic [7:0]  o_segout4,
   output logic [7:0]  o_segout5,
   output logic [7:0]  o_segout6,
   output logic [1:0]  o_src
);

   localparam int TMAX = HOLD_MS > MSG_MS ? HOLD_MS : MSG_MS;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int BW   = BLINK_MS > 1 ? $clog2(BLINK_MS) : 1;

   disp_state_e state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic          pend_q, pend_d;
   logic [47:0]   lap_q, lap_d, msg_q, msg_d, seg_q, seg_d;
   logic [1:0]    src_q, src_d;
   logic          lap_ack_q, msg_ack_q;
   logic          tick, expire, blink_wrap;
   digits_t       digs;

   ms_tick_gen #(.DIV_TICK(DIV_TICK)) u_tick (
      .clk_i  (i_sclk),
      .rst_ni (i_reset_n),
      .tick_o (tick)
   );

   assign expire     = tick && timer_q <= TW'(1);
   assign blink_wrap = blink_q == BW'(BLINK_MS - 1);
   assign lap_d      = i_lap_req ? i_lap_segs : lap_q;
   assign msg_d      = i_msg_req ? i_msg_segs : msg_q;

   // One lap buffer serves as both the displayed snapshot and the pending buffer:
   // while MSG is shown the lap data is invisible, so overwriting it is safe.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      blink_d = blink_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      if (i_msg_req) begin
         state_d = MSG;
         timer_d = TW'(MSG_MS);
         pend_d  = pend_q | i_lap_req;
      end else if (i_lap_req && state_q != MSG) begin
         state_d = LAP;
         timer_d = TW'(HOLD_MS);
         phase_d = 1'b1;
         blink_d = '0;
      end else if (state_q == MSG) begin
         if (expire) begin
            state_d = (pend_q || i_lap_req) ? LAP : LIVE;
            timer_d = TW'(HOLD_MS);
            phase_d = 1'b1;
            blink_d = '0;
            pend_d  = 1'b0;
         end else begin
            pend_d  = pend_q | i_lap_req;
            timer_d = tick ? timer_q - 1'b1 : timer_q;
         end
      end else if (state_q == LAP && tick) begin
         state_d = expire ? LIVE : LAP;
         timer_d = timer_q - 1'b1;
         blink_d = blink_wrap ? '0 : blink_q + 1'b1;
         phase_d = phase_q ^ (BLINK_MS != 0 && blink_wrap);
      end
   end

   assign seg_d = state_q == MSG ? msg_q :
                  state_q == LAP ? (phase_q ? lap_q : ALL_BLANK) : i_live_segs;
   assign src_d = state_q == MSG ? SRC_MSG : state_q == LAP ? SRC_LAP : SRC_LIVE;

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= LIVE;
         timer_q   <= '0;
         blink_q   <= '0;
         phase_q   <= 1'b1;
         pend_q    <= 1'b0;
         lap_q     <= '0;
         msg_q     <= '0;
         seg_q     <= ALL_BLANK;
         src_q     <= SRC_LIVE;
         lap_ack_q <= 1'b0;
         msg_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         blink_q   <= blink_d;
         phase_q   <= phase_d;
         pend_q    <= pend_d;
         lap_q     <= lap_d;
         msg_q     <= msg_d;
         seg_q     <= seg_d;
         src_q     <= src_d;
         lap_ack_q <= i_lap_req;
         msg_ack_q <= i_msg_req;
      end
   end

   assign digs      = unpack_digits(seg_q);
   assign o_segout1 = digs[0];
   assign o_segout2 = digs[1];
   assign o_segout3 = digs[2];
   assign o_segout4 = digs[3];
   assign o_segout5 = digs[4];
   assign o_segout6 = digs[5];
   assign o_src     = src_q;
   assign o_lap_ack = lap_ack_q;
   assign o_msg_ack = msg_ack_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: vector table, directed corner sequences and random traffic
// checked against a tick-counting behavioural model.
module tb_seg_display_arbiter;

   localparam int DIV = 4, HOLD = 6, MSGT = 4, BLINK = 2;
   localparam logic [47:0] BLANK = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        lr = 1'b0, mr = 1'b0;
   logic [47:0] live = '0, lap = '0, msg = '0;
   logic        lack, mack;
   logic [7:0]  s1, s2, s3, s4, s5, s6;
   logic [1:0]  src;
   logic [47:0] segs;

   always #5 clk = ~clk;

   seg_display_arbiter #(.DIV_TICK(DIV), .HOLD_MS(HOLD), .MSG_MS(MSGT), .BLINK_MS(BLINK)) dut (
      .i_sclk(clk), .i_reset_n(rst_n), .i_live_segs(live),
      .i_lap_req(lr), .i_lap_segs(lap), .i_msg_req(mr), .i_msg_segs(msg),
      .o_lap_ack(lack), .o_msg_ack(mack),
      .o_segout1(s1), .o_segout2(s2), .o_segout3(s3),
      .o_segout4(s4), .o_segout5(s5), .o_segout6(s6), .o_src(src)
   );

   assign segs = {s6, s5, s4, s3, s2, s1};

   int total = 0, bad = 0;

   // Model: mode 0 live, 1 lap, 2 msg; rem = ticks left; el = ticks since lap shown.
   int          mode, rem, el, cyc;
   bit          pend;
   logic [47:0] lapb, msgb, e_seg;
   logic [1:0]  e_src, e_ack;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode = 0; rem = 0; el = 0; cyc = 0; pend = 0;
      e_seg = BLANK; e_src = 2'b00; e_ack = 2'b00;
   endtask

   task automatic start_lap();
      mode = 1; rem = HOLD; el = 0;
   endtask

   task automatic model_step();
      bit tick;
      tick = cyc > 0 && cyc % DIV == 0;
      cyc++;
      e_seg = mode == 0 ? live : mode == 2 ? msgb :
              ((el / BLINK) % 2 == 0) ? lapb : BLANK;
      e_src = 2'(mode);
      e_ack = {lr, mr};
      if (lr) lapb = lap;
      if (mr) begin
         msgb = msg; mode = 2; rem = MSGT; pend = pend | lr;
      end else if (lr && mode != 2) begin
         start_lap();
      end else if (mode == 2) begin
         pend = pend | lr;
         if (tick) begin
            rem--;
            if (rem == 0) begin
               if (pend) start_lap(); else mode = 0;
               pend = 0;
            end
         end
      end else if (mode == 1 && tick) begin
         rem--; el++;
         if (rem == 0) mode = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("segs", segs, e_seg);
      chk("src", {46'd0, src}, {46'd0, e_src});
      chk("acks", {46'd0, lack, mack}, {46'd0, e_ack});
   endtask

   task automatic idle(input int n);
      lr = 0; mr = 0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   typedef struct {
      logic        lr;
      logic [47:0] lap;
      logic [47:0] live;
      logic [47:0] eseg;
      logic [1:0]  esrc;
      logic [1:0]  eack;
   } vec_t;

   vec_t tv[10];

   initial begin
      logic [47:0] va, vb, vc, lp, lp2, mx;
      va = 48'hC0F9A4B09992; vb = 48'h82F880909EA1; vc = 48'h8EC6A1868E88;
      lp = 48'h112233445566; lp2 = 48'hDEADBEEF0000;
      tv[0] = '{0, '0, va, va, 2'b00, 2'b00};
      tv[1] = '{0, '0, vb, vb, 2'b00, 2'b00};
      tv[2] = '{1, lp, vb, vb, 2'b00, 2'b10};
      tv[3] = '{0, lp2, vc, lp, 2'b01, 2'b00};
      for (int i = 4; i < 9; i++) tv[i] = '{0, lp2, vc, lp, 2'b01, 2'b00};
      tv[9] = '{0, lp2, vc, BLANK, 2'b01, 2'b00};

      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_segs", segs, BLANK);
      chk("rst_src", {46'd0, src}, 48'd0);
      chk("rst_acks", {46'd0, lack, mack}, 48'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         lr = tv[i].lr; lap = tv[i].lap; live = tv[i].live;
         cycle();
         chk($sformatf("vec%0d_segs", i), segs, tv[i].eseg);
         chk($sformatf("vec%0d_src", i), {46'd0, src}, {46'd0, tv[i].esrc});
         chk($sformatf("vec%0d_acks", i), {46'd0, lack, mack}, {46'd0, tv[i].eack});
      end
      idle(24);
      chk("lap_done_src", {46'd0, src}, 48'd0);

      lr = 1; mr = 1; lap = 48'hA1A2A3A4A5A6; msg = 48'hB1B2B3B4B5B6;
      cycle();
      chk("both_acks", {46'd0, lack, mack}, 48'd3);
      idle(70);

      lr = 1; lap = 48'h010203040506; cycle();
      idle(5 * DIV);
      lr = 1; lap = 48'h0A0B0C0D0E0F; cycle();
      idle(3);
      chk("relap_segs", segs, 48'h0A0B0C0D0E0F);
      idle(30);

      mx = 48'h9192939495A6;
      mr = 1; msg = mx; cycle();
      mr = 0; msg = 48'h000000000000; cycle();
      cycle();
      chk("msg_held", segs, mx);
      idle(20);

      live = 48'h8888888888C0;
      lr = 1; lap = 48'h777777777777; cycle();
      idle(6);
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_segs", segs, BLANK);
      chk("midrst_src", {46'd0, src}, 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("seg1_after_rst", {40'd0, s1}, 48'hC0);

      for (int i = 0; i < 1500; i++) begin
         lr = $urandom_range(0, 14) == 0;
         mr = $urandom_range(0, 24) == 0;
         lap = {$urandom, $urandom};
         msg = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) live = {$urandom, $urandom};
         cycle();
      end
      idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
